// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
//   ID stage of the non-pipelined RV32I core. Decodes the instruction word from
//   IF, generates the sign-extended immediate, reads both source operands from
//   the 32x32 integer register file and presents everything to EX, registered,
//   one clock later. The WB port writes the register file.
//
// Ports
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   instr_in            32-bit instruction word from IF
//   wb_en/wb_rd/wb_data register file write port from WB
//   rs1_data, rs2_data  source operand values (with same-edge WB bypass)
//   imm                 sign-extended immediate
//   rd, funct3,         instruction fields for EX/WB
//   funct7_b5
//   alu_src_imm ...     decoded control flags; illegal flags unknown opcodes
// -----------------------------------------------------------------------------
module instruction_decode #(
    parameter bit DEBUG = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic        funct7_b5,
    output logic        alu_src_imm,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        is_branch,
    output logic        is_jal,
    output logic        is_jalr,
    output logic        is_lui,
    output logic        is_auipc,
    output logic        illegal
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Everything handed to EX, captured as one registered bundle.
    typedef struct packed {
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic              funct7_b5;
        logic              alu_src_imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              is_branch;
        logic              is_jal;
        logic              is_jalr;
        logic              is_lui;
        logic              is_auipc;
        logic              illegal;
    } id_out_t;

    id_out_t out_d;
    id_out_t out_q;

    logic [XLEN-1:0] regs_q [NUM_REGS];

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1_idx;
    logic [REG_AW-1:0] rs2_idx;
    logic              wb_we;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_s;
    logic [XLEN-1:0]   imm_b;
    logic [XLEN-1:0]   imm_u;
    logic [XLEN-1:0]   imm_j;

    // Field extraction and immediate formats.
    assign opcode  = instr_in[6:0];
    assign rs1_idx = instr_in[19:15];
    assign rs2_idx = instr_in[24:20];
    assign wb_we   = wb_en && (wb_rd != '0);

    assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                    instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u = {instr_in[31:12], 12'b0};
    assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                    instr_in[20], instr_in[30:21], 1'b0};

    // Decode and operand read for the instruction captured on the next edge.
    always_comb begin
        out_d           = '0;
        out_d.rd        = instr_in[11:7];
        out_d.funct3    = instr_in[14:12];
        out_d.funct7_b5 = instr_in[30];

        // A write landing on the same edge wins over the stale register value.
        out_d.rs1_data = (wb_we && (wb_rd == rs1_idx)) ? wb_data : regs_q[rs1_idx];
        out_d.rs2_data = (wb_we && (wb_rd == rs2_idx)) ? wb_data : regs_q[rs2_idx];

        unique case (opcode)
            OP_R: begin
                out_d.reg_write = 1'b1;
            end
            OP_I_ALU: begin
                out_d.reg_write   = 1'b1;
                out_d.alu_src_imm = 1'b1;
                out_d.imm         = imm_i;
            end
            OP_LOAD: begin
                out_d.reg_write   = 1'b1;
                out_d.alu_src_imm = 1'b1;
                out_d.mem_read    = 1'b1;
                out_d.imm         = imm_i;
            end
            OP_STORE: begin
                out_d.alu_src_imm = 1'b1;
                out_d.mem_write   = 1'b1;
                out_d.imm         = imm_s;
                out_d.rd          = '0;
            end
            OP_BRANCH: begin
                out_d.is_branch = 1'b1;
                out_d.imm       = imm_b;
                out_d.rd        = '0;
            end
            OP_JAL: begin
                out_d.is_jal    = 1'b1;
                out_d.reg_write = 1'b1;
                out_d.imm       = imm_j;
            end
            OP_JALR: begin
                out_d.is_jalr     = 1'b1;
                out_d.reg_write   = 1'b1;
                out_d.alu_src_imm = 1'b1;
                out_d.imm         = imm_i;
            end
            OP_LUI: begin
                out_d.is_lui    = 1'b1;
                out_d.reg_write = 1'b1;
                out_d.imm       = imm_u;
            end
            OP_AUIPC: begin
                out_d.is_auipc  = 1'b1;
                out_d.reg_write = 1'b1;
                out_d.imm       = imm_u;
            end
            default: begin
                // The all-zero word is IF's bubble: a quiet NOP, not illegal.
                if (instr_in != '0) begin
                    out_d.illegal = 1'b1;
                end
            end
        endcase
    end

    // Output register bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    // Register file; x0 is never written so it always reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    assign rs1_data    = out_q.rs1_data;
    assign rs2_data    = out_q.rs2_data;
    assign imm         = out_q.imm;
    assign rd          = out_q.rd;
    assign funct3      = out_q.funct3;
    assign funct7_b5   = out_q.funct7_b5;
    assign alu_src_imm = out_q.alu_src_imm;
    assign reg_write   = out_q.reg_write;
    assign mem_read    = out_q.mem_read;
    assign mem_write   = out_q.mem_write;
    assign is_branch   = out_q.is_branch;
    assign is_jal      = out_q.is_jal;
    assign is_jalr     = out_q.is_jalr;
    assign is_lui      = out_q.is_lui;
    assign is_auipc    = out_q.is_auipc;
    assign illegal     = out_q.illegal;

    // Optional per-clock trace of the instruction being captured.
    if (DEBUG) begin : g_debug
        always @(posedge clk) begin
            $display("[ID-PHASE] INSTR: 0x%08h RD: %0d IMM: 0x%08h",
                     instr_in, out_d.rd, out_d.imm);
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed vector table, randomized run against
// a spec-level reference model, and a mid-cycle asynchronous reset sequence.
module tb_instruction_decode;

    localparam logic [9:0] C_ALU  = 10'h200;
    localparam logic [9:0] C_RW   = 10'h100;
    localparam logic [9:0] C_MR   = 10'h080;
    localparam logic [9:0] C_MW   = 10'h040;
    localparam logic [9:0] C_BR   = 10'h020;
    localparam logic [9:0] C_JAL  = 10'h010;
    localparam logic [9:0] C_JALR = 10'h008;
    localparam logic [9:0] C_LUI  = 10'h004;
    localparam logic [9:0] C_AUI  = 10'h002;
    localparam logic [9:0] C_ILL  = 10'h001;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7;
        logic [9:0]  ctl;
    } outs_t;

    typedef struct {
        logic [31:0] instr;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        outs_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7_b5, alu_src_imm, reg_write, mem_read, mem_write;
    logic        is_branch, is_jal, is_jalr, is_lui, is_auipc, illegal;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ref_regs [32];
    vec_t tbl [10];

    always #5 clk = ~clk;

    instruction_decode #(.DEBUG(1'b0)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
        .funct3(funct3), .funct7_b5(funct7_b5), .alu_src_imm(alu_src_imm),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .is_lui(is_lui), .is_auipc(is_auipc), .illegal(illegal)
    );

    function automatic outs_t mk(logic [31:0] r1, logic [31:0] r2, logic [31:0] im,
                                 logic [4:0] d, logic [2:0] f3, logic f7, logic [9:0] c);
        outs_t o;
        o.rs1 = r1; o.rs2 = r2; o.imm = im; o.rd = d; o.f3 = f3; o.f7 = f7; o.ctl = c;
        return o;
    endfunction

    // Reference decode built from the opcode table and immediate bit layouts
    // using integer arithmetic; operand values are filled in by the caller.
    function automatic outs_t model_dec(logic [31:0] ins);
        outs_t o;
        logic signed [31:0] s;
        int hi;
        int v;
        s = ins;
        o = '0;
        o.rd = ins[11:7];
        o.f3 = ins[14:12];
        o.f7 = ins[30];
        case (ins[6:0])
            7'h33: o.ctl = C_RW;
            7'h13: begin o.ctl = C_RW | C_ALU;        hi = s >>> 20; o.imm = 32'(hi); end
            7'h03: begin o.ctl = C_RW | C_ALU | C_MR; hi = s >>> 20; o.imm = 32'(hi); end
            7'h67: begin o.ctl = C_RW | C_ALU | C_JALR; hi = s >>> 20; o.imm = 32'(hi); end
            7'h23: begin
                o.ctl = C_ALU | C_MW; o.rd = 5'd0;
                hi = s >>> 25;
                v = hi * 32 + int'(ins[11:7]);
                o.imm = 32'(v);
            end
            7'h63: begin
                o.ctl = C_BR; o.rd = 5'd0;
                v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                    + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                o.imm = 32'(v);
            end
            7'h6F: begin
                o.ctl = C_RW | C_JAL;
                v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096
                    + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
                o.imm = 32'(v);
            end
            7'h37: begin o.ctl = C_RW | C_LUI; o.imm = ins & 32'hFFFF_F000; end
            7'h17: begin o.ctl = C_RW | C_AUI; o.imm = ins & 32'hFFFF_F000; end
            default: begin
                if (ins == 32'h0) o = '0;
                else o.ctl = C_ILL;
            end
        endcase
        return o;
    endfunction

    function automatic outs_t dut_outs();
        return mk(rs1_data, rs2_data, imm, rd, funct3, funct7_b5,
                  {alu_src_imm, reg_write, mem_read, mem_write, is_branch,
                   is_jal, is_jalr, is_lui, is_auipc, illegal});
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, outs_t exp);
        outs_t a;
        a = dut_outs();
        cmp({tag, ".rs1_data"}, a.rs1, exp.rs1);
        cmp({tag, ".rs2_data"}, a.rs2, exp.rs2);
        cmp({tag, ".imm"},      a.imm, exp.imm);
        cmp({tag, ".rd"},       32'(a.rd), 32'(exp.rd));
        cmp({tag, ".f3_f7_ctl"}, 32'({a.f3, a.f7, a.ctl}), 32'({exp.f3, exp.f7, exp.ctl}));
    endtask

    // Drive at a negedge, let one posedge capture, return at the next negedge.
    task automatic apply(logic [31:0] ins, logic we, logic [4:0] wrd, logic [31:0] wd);
        instr_in = ins; wb_en = we; wb_rd = wrd; wb_data = wd;
        @(posedge clk);
        if (we && wrd != 5'd0) ref_regs[wrd] = wd;
        @(negedge clk);
    endtask

    function automatic outs_t model_full(logic [31:0] ins, logic we, logic [4:0] wrd,
                                         logic [31:0] wd);
        outs_t o;
        o = model_dec(ins);
        o.rs1 = (we && wrd != 5'd0 && wrd == ins[19:15]) ? wd : ref_regs[ins[19:15]];
        o.rs2 = (we && wrd != 5'd0 && wrd == ins[24:20]) ? wd : ref_regs[ins[24:20]];
        return o;
    endfunction

    initial begin
        logic [6:0] ops [9];
        outs_t e;
        logic [31:0] r, ins;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wd;
        int k;

        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;

        tbl[0] = '{32'h0000_0000, 1'b0, 5'd0, 32'h0,
                   mk(32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 10'h0)};
        tbl[1] = '{32'hFFF0_0093, 1'b0, 5'd0, 32'h0,
                   mk(32'h0, 32'h0, 32'hFFFF_FFFF, 5'd1, 3'd0, 1'b1, C_ALU | C_RW)};
        tbl[2] = '{32'h0002_80B3, 1'b1, 5'd5, 32'h1234_5678,
                   mk(32'h1234_5678, 32'h0, 32'h0, 5'd1, 3'd0, 1'b0, C_RW)};
        tbl[3] = '{32'h0002_80B3, 1'b0, 5'd0, 32'h0,
                   mk(32'h1234_5678, 32'h0, 32'h0, 5'd1, 3'd0, 1'b0, C_RW)};
        tbl[4] = '{32'h0000_0033, 1'b1, 5'd0, 32'hFFFF_FFFF,
                   mk(32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, C_RW)};
        tbl[5] = '{32'h0000_0033, 1'b0, 5'd0, 32'h0,
                   mk(32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, C_RW)};
        tbl[6] = '{32'hFE00_0EE3, 1'b0, 5'd0, 32'h0,
                   mk(32'h0, 32'h0, 32'hFFFF_FFFC, 5'd0, 3'd0, 1'b1, C_BR)};
        tbl[7] = '{32'h0011_2223, 1'b1, 5'd2, 32'h0000_0100,
                   mk(32'h0000_0100, 32'h0, 32'h0000_0004, 5'd0, 3'd2, 1'b0, C_ALU | C_MW)};
        tbl[8] = '{32'h0000_007F, 1'b0, 5'd0, 32'h0,
                   mk(32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, C_ILL)};
        tbl[9] = '{32'h1234_50B7, 1'b0, 5'd0, 32'h0,
                   mk(32'h0, 32'h0, 32'h1234_5000, 5'd1, 3'd5, 1'b0, C_LUI | C_RW)};

        // Power-on reset.
        rst = 1'b1; instr_in = 32'h0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        repeat (2) @(negedge clk);
        check_all("reset", '0);
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].instr, tbl[i].wb_en, tbl[i].wb_rd, tbl[i].wb_data);
            check_all($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Randomized run against the reference model.
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            k = int'($urandom_range(0, 10));
            if (k < 9)       ins = {r[31:7], ops[k]};
            else if (k == 9) ins = r;
            else             ins = 32'h0;
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       wrd = ins[19:15];
                1:       wrd = ins[24:20];
                default: wrd = 5'($urandom_range(0, 31));
            endcase
            wd = $urandom();
            e = model_full(ins, we, wrd, wd);
            apply(ins, we, wrd, wd);
            check_all($sformatf("rand%0d", n), e);
        end

        // Mid-cycle reset while outputs are nonzero, with a writeback pending.
        apply(32'hFFF0_0093, 1'b0, 5'd0, 32'h0);
        instr_in = 32'hFFF0_0093; wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
        #1 rst = 1'b1;
        #1 check_all("async_rst", '0);
        @(negedge clk);
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        rst = 1'b0;
        // x7 (dropped writeback) and x5 (cleared) must both read zero.
        apply(32'h0053_8033, 1'b0, 5'd0, 32'h0);
        check_all("post_rst_read", mk(32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, C_RW));
        apply(32'h0000_0000, 1'b0, 5'd0, 32'h0);
        check_all("post_rst_bubble", '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
